// File: rtl/music_seq_ctrl_if.sv
// Key-scan to playback-sequencer bundle: debounced key pulses and repeat level in,
// ROM address, beat tick and speaker qualifiers out.
// Ports: key_play/key_stop/key_next/key_tempo_up/key_tempo_dn (1-cycle pulses), repeat_en (level)
//        rom_addr[7:0], beat_tick, playing, mute, song_sel, tempo[2:0], song_done (all registered).
// master = key-scan side (drives keys), slave = sequencer (drives playback outputs).
interface music_seq_ctrl_if;
    logic       key_play;
    logic       key_stop;
    logic       key_next;
    logic       key_tempo_up;
    logic       key_tempo_dn;
    logic       repeat_en;
    logic [7:0] rom_addr;
    logic       beat_tick;
    logic       playing;
    logic       mute;
    logic       song_sel;
    logic [2:0] tempo;
    logic       song_done;

    modport master (
        output key_play, key_stop, key_next, key_tempo_up, key_tempo_dn, repeat_en,
        input  rom_addr, beat_tick, playing, mute, song_sel, tempo, song_done
    );

    modport slave (
        input  key_play, key_stop, key_next, key_tempo_up, key_tempo_dn, repeat_en,
        output rom_addr, beat_tick, playing, mute, song_sel, tempo, song_done
    );
endinterface

// File: rtl/music_seq_ctrl.sv
// Playback sequencer: beat divider with programmable tempo, score ROM address walk,
// play/pause/stop/next-song/repeat control and speaker mute qualifier.
// Latency: a key pulse in cycle n is visible on the registered outputs in cycle n+1; no backpressure.
// Ports: clk, rst (sync, active-high), bus (music_seq_ctrl_if.slave).
// Optional articulation gap: define MUSIC_SEQ_ARTIC_GAP_EN to mute the last GAP_CYC cycles of each beat.
module music_seq_ctrl #(
    parameter int BASE_DIV    = 250000,
    parameter int TEMPO_STEP  = 25000,
    parameter int SONG0_START = 0,
    parameter int SONG0_LEN   = 139,
    parameter int SONG1_START = 139,
    parameter int SONG1_LEN   = 117,
    parameter int GAP_CYC     = 12500
) (
    input  logic              clk,
    input  logic              rst,
    music_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [7:0]  S0_FIRST = 8'(SONG0_START);
    localparam logic [7:0]  S0_LAST  = 8'(SONG0_START + SONG0_LEN - 1);
    localparam logic [7:0]  S1_FIRST = 8'(SONG1_START);
    localparam logic [7:0]  S1_LAST  = 8'(SONG1_START + SONG1_LEN - 1);
    localparam logic [19:0] BASE_P   = 20'(BASE_DIV);
    localparam logic [19:0] STEP_P   = 20'(TEMPO_STEP);

    // Elaboration-time guard: the gap must fit inside the shortest beat.
    if (GAP_CYC >= BASE_DIV - 7 * TEMPO_STEP) begin : g_bad_gap
        $error("music_seq_ctrl: GAP_CYC must be shorter than the fastest beat period");
    end

`ifdef MUSIC_SEQ_ARTIC_GAP_EN
    localparam logic [19:0] GAP_P = 20'(GAP_CYC);
`endif

    state_t      state_q,     state_d;
    logic        song_sel_q,  song_sel_d;
    logic [2:0]  tempo_q,     tempo_d;
    logic [7:0]  rom_addr_q,  rom_addr_d;
    logic [19:0] cnt_q,       cnt_d;
    logic [19:0] period_q,    period_d;
    logic        beat_tick_q, beat_tick_d;
    logic        song_done_q, song_done_d;
    logic        playing_q,   playing_d;
    logic        mute_q,      mute_d;

    logic [7:0]  cur_first;
    logic [7:0]  cur_last;
    logic [7:0]  oth_first;
    logic [19:0] tempo_period;
    logic        beat_end;

    always_comb begin
        cur_first    = song_sel_q ? S1_FIRST : S0_FIRST;
        cur_last     = song_sel_q ? S1_LAST  : S0_LAST;
        oth_first    = song_sel_q ? S0_FIRST : S1_FIRST;
        // Period for the tempo currently held; only copied into period_q at latch points.
        tempo_period = BASE_P - (20'(tempo_q) * STEP_P);
        beat_end     = (cnt_q == (period_q - 20'd1));

        state_d     = state_q;
        song_sel_d  = song_sel_q;
        tempo_d     = tempo_q;
        rom_addr_d  = rom_addr_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        beat_tick_d = 1'b0;
        song_done_d = 1'b0;

        // Tempo keys act in every state; both together cancel.
        if (bus.key_tempo_up && !bus.key_tempo_dn && (tempo_q != 3'd7)) begin
            tempo_d = tempo_q + 3'd1;
        end else if (bus.key_tempo_dn && !bus.key_tempo_up && (tempo_q != 3'd0)) begin
            tempo_d = tempo_q - 3'd1;
        end

        // stop > next > play; a stop or next also swallows a coincident beat boundary.
        if (bus.key_stop) begin
            state_d    = ST_IDLE;
            rom_addr_d = cur_first;
            cnt_d      = '0;
        end else if (bus.key_next) begin
            song_sel_d = ~song_sel_q;
            rom_addr_d = oth_first;
            cnt_d      = '0;
            if (state_q == ST_PLAY) begin
                period_d = tempo_period;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.key_play) begin
                        state_d  = ST_PLAY;
                        cnt_d    = '0;
                        period_d = tempo_period;
                    end
                end
                ST_PLAY: begin
                    if (beat_end) begin
                        cnt_d       = '0;
                        beat_tick_d = 1'b1;
                        period_d    = tempo_period;
                        if (rom_addr_q != cur_last) begin
                            rom_addr_d = rom_addr_q + 8'd1;
                        end else begin
                            rom_addr_d = cur_first;
                            if (!bus.repeat_en) begin
                                song_done_d = 1'b1;
                                state_d     = ST_IDLE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                    // Pause still lets a coincident beat advance; if the song just
                    // ended the sequencer parks in IDLE and the play press is dropped.
                    if (bus.key_play && !song_done_d) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.key_play) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        playing_d = (state_d == ST_PLAY);
`ifdef MUSIC_SEQ_ARTIC_GAP_EN
        // Computed from next-cycle count/period so the registered mute lines up with cnt_q.
        mute_d = !playing_d || (cnt_d >= (period_d - GAP_P));
`else
        mute_d = !playing_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            song_sel_q  <= 1'b0;
            tempo_q     <= 3'd0;
            rom_addr_q  <= S0_FIRST;
            cnt_q       <= '0;
            period_q    <= BASE_P;
            beat_tick_q <= 1'b0;
            song_done_q <= 1'b0;
            playing_q   <= 1'b0;
            mute_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            song_sel_q  <= song_sel_d;
            tempo_q     <= tempo_d;
            rom_addr_q  <= rom_addr_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            beat_tick_q <= beat_tick_d;
            song_done_q <= song_done_d;
            playing_q   <= playing_d;
            mute_q      <= mute_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.beat_tick = beat_tick_q;
    assign bus.playing   = playing_q;
    assign bus.mute      = mute_q;
    assign bus.song_sel  = song_sel_q;
    assign bus.tempo     = tempo_q;
    assign bus.song_done = song_done_q;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Bench for music_seq_ctrl with small parameters (beat 10 cycles, songs 0/4 and 4/3, gap 2).
// Directed scenarios pin exact timings with literals; a random phase follows; a negedge
// compare process checks every output each cycle against a song-position model.
module tb_music_seq_ctrl;

    localparam int G = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    music_seq_ctrl_if bus ();

    music_seq_ctrl #(
        .BASE_DIV(10), .TEMPO_STEP(1),
        .SONG0_START(0), .SONG0_LEN(4),
        .SONG1_START(4), .SONG1_LEN(3),
        .GAP_CYC(G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    // Model: mode 0=stopped 1=playing 2=paused; position is an index within the song.
    int s_start [2] = '{0, 4};
    int s_len   [2] = '{4, 3};
    int m_st, m_song, m_tempo, m_idx, m_cnt, m_per;
    bit m_tick, m_done;

    task automatic model_clk();
        bit p, s, n, u, d, r;
        int t_next;
        p = bus.key_play; s = bus.key_stop; n = bus.key_next;
        u = bus.key_tempo_up; d = bus.key_tempo_dn; r = bus.repeat_en;
        m_tick = 0;
        m_done = 0;
        if (rst) begin
            m_st = 0; m_song = 0; m_tempo = 0; m_idx = 0; m_cnt = 0; m_per = 10;
            return;
        end
        t_next = m_tempo;
        if (u && !d && m_tempo < 7) t_next = m_tempo + 1;
        if (d && !u && m_tempo > 0) t_next = m_tempo - 1;
        if (s) begin
            m_st = 0; m_idx = 0; m_cnt = 0;
        end else if (n) begin
            m_song = 1 - m_song; m_idx = 0; m_cnt = 0;
            if (m_st == 1) m_per = 10 - m_tempo;
        end else if (m_st == 0) begin
            if (p) begin m_st = 1; m_cnt = 0; m_per = 10 - m_tempo; end
        end else if (m_st == 1) begin
            if (m_cnt == m_per - 1) begin
                m_cnt = 0; m_tick = 1; m_per = 10 - m_tempo;
                if (m_idx < s_len[m_song] - 1) m_idx = m_idx + 1;
                else begin
                    m_idx = 0;
                    if (!r) begin m_done = 1; m_st = 0; end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (p && m_st == 1) m_st = 2;
        end else begin
            if (p) m_st = 1;
        end
        m_tempo = t_next;
    endtask

    function automatic bit exp_mute();
        if (m_st != 1) return 1'b1;
`ifdef MUSIC_SEQ_ARTIC_GAP_EN
        return (m_cnt >= m_per - G);
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [15:0] act, exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                act = {bus.rom_addr, bus.beat_tick, bus.playing, bus.mute, bus.song_sel,
                       bus.tempo, bus.song_done};
                exp = {8'(s_start[m_song] + m_idx), m_tick, (m_st == 1), exp_mute(),
                       m_song[0], 3'(m_tempo), m_done};
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL cycle_compare cyc=%0d got addr=%0d tick=%b play=%b mute=%b song=%b tempo=%0d done=%b expected addr=%0d tick=%b play=%b mute=%b song=%b tempo=%0d done=%b",
                             cyc, act[15:8], act[7], act[6], act[5], act[4], act[3:1], act[0],
                             exp[15:8], exp[7], exp[6], exp[5], exp[4], exp[3:1], exp[0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        @(negedge clk);
        cyc++;
    endtask

    task automatic keys(input bit p, input bit s, input bit n, input bit u, input bit d);
        bus.key_play = p; bus.key_stop = s; bus.key_next = n;
        bus.key_tempo_up = u; bus.key_tempo_dn = d;
        step();
        bus.key_play = 0; bus.key_stop = 0; bus.key_next = 0;
        bus.key_tempo_up = 0; bus.key_tempo_dn = 0;
    endtask

    task automatic wait_tick(input string nm);
        int k;
        step();
        k = 0;
        while (bus.beat_tick !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        if (bus.beat_tick !== 1'b1) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int t0, t1, bad_mute, bad_tick;
        bit em;
        bus.key_play = 0; bus.key_stop = 0; bus.key_next = 0;
        bus.key_tempo_up = 0; bus.key_tempo_dn = 0; bus.repeat_en = 0;

        // Reset
        rst = 1;
        step();
        chk_en = 1;
        step();
        rst = 0;
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_mute", bus.mute, 1);
        chk("rst_playing", bus.playing, 0);
        chk("rst_tempo", bus.tempo, 0);
        chk("rst_song", bus.song_sel, 0);

        // Song 0 straight through, no repeat
        keys(1, 0, 0, 0, 0);
        chk("s2_playing", bus.playing, 1);
        chk("s2_mute_play", bus.mute, (G > 100) ? 1 : 0);
        for (int i = 1; i <= 4; i++) begin
            t0 = cyc;
            wait_tick("s2_tick");
            chk("s2_period", cyc - t0, 10);
            chk("s2_addr", bus.rom_addr, i % 4);
        end
        chk("s2_done", bus.song_done, 1);
        chk("s2_stopped", bus.playing, 0);
        step();
        chk("s2_done_pulse", bus.song_done, 0);

        // Song 1 with repeat
        keys(0, 0, 1, 0, 0);
        chk("s3_song", bus.song_sel, 1);
        chk("s3_addr", bus.rom_addr, 4);
        bus.repeat_en = 1;
        keys(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            wait_tick("s3_tick");
            chk("s3_addr_seq", bus.rom_addr, 4 + ((i + 1) % 3));
            chk("s3_no_done", bus.song_done, 0);
        end
        keys(0, 1, 0, 0, 0);
        chk("s3_stop_addr", bus.rom_addr, 4);
        bus.repeat_en = 0;

        // Pause at count 5 and resume
        keys(0, 0, 1, 0, 0);
        keys(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        keys(1, 0, 0, 0, 0);
        bad_mute = 0; bad_tick = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.mute !== 1'b1) bad_mute++;
            if (bus.beat_tick !== 1'b0) bad_tick++;
            step();
        end
        chk("s4_pause_mute", bad_mute, 0);
        chk("s4_pause_tick", bad_tick, 0);
        chk("s4_pause_addr", bus.rom_addr, 0);
        keys(1, 0, 0, 0, 0);
        t0 = cyc;
        wait_tick("s4_resume");
        chk("s4_resume_delay", cyc - t0, 4);
        chk("s4_resume_addr", bus.rom_addr, 1);

        // Tempo changes apply from the next beat
        keys(0, 1, 0, 0, 0);
        bus.repeat_en = 1;
        keys(1, 0, 0, 0, 0);
        t0 = cyc;
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 3; i++) keys(0, 0, 0, 1, 0);
        chk("s5_tempo3", bus.tempo, 3);
        wait_tick("s5_t1");
        chk("s5_beat_old", cyc - t0, 10);
        t1 = cyc;
        wait_tick("s5_t2");
        chk("s5_beat_new", cyc - t1, 7);
        for (int i = 0; i < 9; i++) keys(0, 0, 0, 1, 0);
        chk("s5_tempo_sat", bus.tempo, 7);
        wait_tick("s5_t3");
        t1 = cyc;
        wait_tick("s5_t4");
        chk("s5_beat_fast", cyc - t1, 3);
        keys(0, 0, 0, 1, 1);
        chk("s5_up_dn", bus.tempo, 7);
        keys(0, 0, 0, 0, 1);
        chk("s5_dn", bus.tempo, 6);

        // Key priority and next-song while playing
        keys(0, 1, 0, 0, 0);
        bus.repeat_en = 0;
        keys(1, 0, 0, 0, 0);
        for (int k = 0; k < 100 && bus.rom_addr != 2; k++) step();
        chk("s6_at_addr2", bus.rom_addr, 2);
        keys(1, 1, 1, 0, 0);
        chk("s6_prio_playing", bus.playing, 0);
        chk("s6_prio_addr", bus.rom_addr, 0);
        chk("s6_prio_song", bus.song_sel, 0);
        keys(1, 0, 0, 0, 0);
        step(); step();
        keys(0, 0, 1, 0, 0);
        chk("s6_next_song", bus.song_sel, 1);
        chk("s6_next_addr", bus.rom_addr, 4);
        chk("s6_next_playing", bus.playing, 1);

        // Mute profile across two beats at tempo 0
        keys(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) keys(0, 0, 0, 0, 1);
        chk("s7_tempo0", bus.tempo, 0);
        keys(1, 0, 0, 0, 0);
        bad_mute = 0;
        for (int k = 0; k < 20; k++) begin
`ifdef MUSIC_SEQ_ARTIC_GAP_EN
            em = ((k % 10) >= 8);
`else
            em = 1'b0;
`endif
            if (bus.mute !== em) bad_mute++;
            step();
        end
        chk("s7_mute_profile", bad_mute, 0);
        keys(0, 1, 0, 0, 0);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            bus.key_play     = ($urandom_range(0, 11) == 0);
            bus.key_stop     = ($urandom_range(0, 59) == 0);
            bus.key_next     = ($urandom_range(0, 49) == 0);
            bus.key_tempo_up = ($urandom_range(0, 19) == 0);
            bus.key_tempo_dn = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) bus.repeat_en = ~bus.repeat_en;
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 0;
        bus.key_play = 0; bus.key_stop = 0; bus.key_next = 0;
        bus.key_tempo_up = 0; bus.key_tempo_dn = 0;
        step();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
